// File: rtl/seq_mul.sv
// -----------------------------------------------------------------------------
// seq_mul -- multi-cycle signed/unsigned shift-add multiplier.
//
// Produces the full 2*WIDTH product of two WIDTH-bit operands. Each operand can
// independently be treated as signed or unsigned. The operands' magnitudes are
// multiplied by shift-add, one multiplier bit per cycle. The sign is applied
// once at the end.
//
// Sequencing: IDLE -> START -> CALC (WIDTH cycles) -> FIN -> IDLE.
// - done_o and prod_o are registered on the FIN exit edge.
// - done_o is therefore seen WIDTH+2 cycles after the accepting edge.
//
// Optional feature (define the macro MUL_EARLY_EXIT_EN):
// - CALC ends as soon as no set multiplier bits remain.
// - START skips CALC entirely for a zero multiplier.
// - Results are identical to the default build; only the latency changes.
//
// Parameters:
//   WIDTH           operand width (4..32); product is 2*WIDTH bits
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   mul_en          start request, honoured only in IDLE
//   multiplicand_i  operand A, captured on the accepting edge
//   multiplier_i    operand B, captured on the accepting edge
//   sign_i          {A_signed, B_signed}, captured with the operands
//   busy_o          high while an operation is in START/CALC/FIN
//   done_o          one-cycle completion pulse; prod_o valid from then on
//   prod_o          2*WIDTH product, held until the next completion
// -----------------------------------------------------------------------------
module seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mul_en,
   input  logic [WIDTH-1:0]     multiplicand_i,
   input  logic [WIDTH-1:0]     multiplier_i,
   input  logic [1:0]           sign_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   prod_o
);

   localparam int RW = $clog2(WIDTH);
   localparam logic [RW-1:0] LAST_ROUND = RW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      CALC  = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic [1:0]          sgn_q;
   logic                neg;
   logic [2*WIDTH-1:0]  acc;
   logic [2*WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]    mplier;
   logic [RW-1:0]       round;

   logic [WIDTH-1:0]    mag_a;
   logic [WIDTH-1:0]    mag_b;

   // Magnitude as an unsigned WIDTH-bit value.
   // The most negative input wraps to 2^(WIDTH-1), which is the correct
   // unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             is_signed);
      if (is_signed && v[WIDTH-1])
         return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      else
         return v;
   endfunction

   // Two's-complement negation of the accumulated magnitude, 2*WIDTH-bit wrap.
   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                     input logic               n);
      if (n)
         return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
      else
         return v;
   endfunction

   assign mag_a = magnitude(a_q, sgn_q[1]);
   assign mag_b = magnitude(b_q, sgn_q[0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sgn_q  <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         round  <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         prod_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               if (mul_en) begin
                  a_q    <= multiplicand_i;
                  b_q    <= multiplier_i;
                  sgn_q  <= sign_i;
                  busy_o <= 1'b1;
                  state  <= START;
               end
            end

            START: begin
               neg    <= (sgn_q[1] & a_q[WIDTH-1]) ^ (sgn_q[0] & b_q[WIDTH-1]);
               acc    <= '0;
               mcand  <= {{WIDTH{1'b0}}, mag_a};
               mplier <= mag_b;
               round  <= '0;
`ifdef MUL_EARLY_EXIT_EN
               // A zero multiplier needs no partial products at all.
               if (mag_b == '0)
                  state <= FIN;
               else
                  state <= CALC;
`else
               state  <= CALC;
`endif
            end

            CALC: begin
               if (mplier[0])
                  acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               round  <= round + RW'(1);
`ifdef MUL_EARLY_EXIT_EN
               // Stop once the post-shift multiplier has no set bits left.
               if (round == LAST_ROUND || mplier[WIDTH-1:1] == '0)
                  state <= FIN;
`else
               if (round == LAST_ROUND)
                  state <= FIN;
`endif
            end

            FIN: begin
               prod_o <= apply_sign(acc, neg);
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

   logic        clk;
   logic        rst;
   logic        mul_en;
   logic [7:0]  multiplicand_i;
   logic [7:0]  multiplier_i;
   logic [1:0]  sign_i;
   logic        busy_o;
   logic        done_o;
   logic [15:0] prod_o;

   int checks;
   int failures;

   seq_mul #(.WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .mul_en         (mul_en),
      .multiplicand_i (multiplicand_i),
      .multiplier_i   (multiplier_i),
      .sign_i         (sign_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .prod_o         (prod_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One operation. lat_off / lat_early are the hand-derived numbers of edges
   // from the accepting edge until done_o is seen, for each build.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] s, input logic [15:0] exp_prod,
                         input int lat_off, input int lat_early);
      int n;
      int lat;
`ifdef MUL_EARLY_EXIT_EN
      lat = lat_early;
`else
      lat = lat_off;
`endif
      multiplicand_i = a;
      multiplier_i   = b;
      sign_i         = s;
      mul_en         = 1'b1;
      @(posedge clk);
      #1;
      mul_en         = 1'b0;
      // Scramble inputs so that only captured operands can produce the result.
      multiplicand_i = ~a;
      multiplier_i   = b ^ 8'h5A;
      sign_i         = ~s;
      check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
      n = 0;
      while (done_o !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_done"}, {31'd0, done_o}, 32'd1);
      check({tag, "_lat"}, n, lat);
      check({tag, "_prod"}, {16'd0, prod_o}, {16'd0, exp_prod});
      check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
   endtask

   initial begin
      int n;
      int pulses;
      int blat;
      checks         = 0;
      failures       = 0;
      rst            = 1'b1;
      mul_en         = 1'b0;
      multiplicand_i = 8'h00;
      multiplier_i   = 8'h00;
      sign_i         = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_prod", {16'd0, prod_o}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("ss_m7x5",   8'hF9, 8'h05, 2'b11, 16'hFFDD, 10, 5);
      run_op("uu_ffxff",  8'hFF, 8'hFF, 2'b00, 16'hFE01, 10, 10);
      run_op("ss_80x80",  8'h80, 8'h80, 2'b11, 16'h4000, 10, 10);
      run_op("ss_80x7f",  8'h80, 8'h7F, 2'b11, 16'hC080, 10, 9);
      run_op("su_ffxff",  8'hFF, 8'hFF, 2'b10, 16'hFF01, 10, 10);
      run_op("uu_3x2",    8'h03, 8'h02, 2'b00, 16'h0006, 10, 4);
      run_op("uu_55x0",   8'h55, 8'h00, 2'b00, 16'h0000, 10, 2);
      run_op("ss_7fxm1",  8'h7F, 8'hFF, 2'b11, 16'hFF81, 10, 3);
      run_op("us_80x1",   8'h80, 8'h01, 2'b01, 16'h0080, 10, 3);

      // mul_en held high with a new multiplicand every cycle (edge k sees k+1).
`ifdef MUL_EARLY_EXIT_EN
      blat = 4;
`else
      blat = 10;
`endif
      pulses       = 0;
      multiplier_i = 8'h03;
      sign_i       = 2'b00;
      mul_en       = 1'b1;
      for (int k = 0; k <= 2 * blat + 1; k++) begin
         multiplicand_i = 8'(k + 1);
         @(posedge clk);
         #1;
         if (done_o === 1'b1) pulses++;
         if (k == blat) begin
            check("b2b_done1", {31'd0, done_o}, 32'd1);
            check("b2b_prod1", {16'd0, prod_o}, 32'd3);
         end
         if (k == 2 * blat + 1) begin
            check("b2b_done2", {31'd0, done_o}, 32'd1);
            check("b2b_prod2", {16'd0, prod_o}, 32'(3 * (blat + 2)));
         end
      end
      mul_en = 1'b0;
      check("b2b_pulses", pulses, 2);
      @(posedge clk);
      #1;

      // Reset mid-CALC: outputs clear at once, and the abandoned op never completes.
      multiplicand_i = 8'hFF;
      multiplier_i   = 8'hFF;
      sign_i         = 2'b00;
      mul_en         = 1'b1;
      @(posedge clk);
      #1;
      mul_en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      check("mid_rst_done", {31'd0, done_o}, 32'd0);
      check("mid_rst_prod", {16'd0, prod_o}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done_o !== 1'b0 || busy_o !== 1'b0) n++;
      end
      check("mid_rst_quiet", n, 0);
      run_op("post_rst",  8'hF9, 8'h05, 2'b11, 16'hFFDD, 10, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
